// File: rtl/stream_demux.sv
// stream_demux: steers valid/ready packets from one input to one of two registered outputs, route locked for the packet.
// Optional macro STREAM_DEMUX_COUNT_EN adds per-output packet counters pkt_cnt0/pkt_cnt1.
module stream_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic             x_valid,
  input  logic             x_last,
  output logic             x_ready,
  input  logic             sel,
  output logic [WIDTH-1:0] OUT0,
  output logic [WIDTH-1:0] OUT1,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out0_last,
  output logic             out1_last,
  input  logic             out0_ready,
  input  logic             out1_ready,
  output logic             busy
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output logic [15:0]      pkt_cnt0,
  output logic [15:0]      pkt_cnt1
`endif
);

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             route_q, route_d;
  logic [WIDTH-1:0] out0_dat_q, out0_dat_d, out1_dat_q, out1_dat_d;
  logic             out0_vld_q, out0_vld_d, out1_vld_q, out1_vld_d;
  logic             out0_last_q, out0_last_d, out1_last_q, out1_last_d;

  logic route;
  logic drain0, drain1;
  logic accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      route_q     <= 1'b0;
      out0_dat_q  <= '0;
      out1_dat_q  <= '0;
      out0_vld_q  <= 1'b0;
      out1_vld_q  <= 1'b0;
      out0_last_q <= 1'b0;
      out1_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      out0_dat_q  <= out0_dat_d;
      out1_dat_q  <= out1_dat_d;
      out0_vld_q  <= out0_vld_d;
      out1_vld_q  <= out1_vld_d;
      out0_last_q <= out0_last_d;
      out1_last_q <= out1_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    route_d     = route_q;
    out0_dat_d  = out0_dat_q;
    out1_dat_d  = out1_dat_q;
    out0_last_d = out0_last_q;
    out1_last_d = out1_last_q;

    drain0 = out0_vld_q & out0_ready;
    drain1 = out1_vld_q & out1_ready;
    // sel only matters on a packet's first beat; afterwards the latched route wins
    route   = (state_q == PKT) ? route_q : sel;
    x_ready = route ? (!out1_vld_q | drain1) : (!out0_vld_q | drain0);
    accept  = x_valid & x_ready;

    out0_vld_d = out0_vld_q & ~out0_ready;
    out1_vld_d = out1_vld_q & ~out1_ready;

    if (accept && !route) begin
      out0_vld_d  = 1'b1;
      out0_dat_d  = X;
      out0_last_d = x_last;
    end
    if (accept && route) begin
      out1_vld_d  = 1'b1;
      out1_dat_d  = X;
      out1_last_d = x_last;
    end

    case (state_q)
      IDLE: begin
        if (accept && !x_last) begin
          state_d = PKT;
          route_d = sel;
        end
      end
      PKT: begin
        if (accept && x_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign OUT0       = out0_dat_q;
  assign OUT1       = out1_dat_q;
  assign out0_valid = out0_vld_q;
  assign out1_valid = out1_vld_q;
  assign out0_last  = out0_last_q;
  assign out1_last  = out1_last_q;
  assign busy       = (state_q == PKT);

`ifdef STREAM_DEMUX_COUNT_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // a packet counts once its last beat leaves the output register; wraps naturally
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (drain0 && out0_last_q) cnt0_d = cnt0_q + 16'd1;
    if (drain1 && out1_last_q) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`endif

endmodule
